// File: rtl/alu_exec_unit.sv
// Handshaked ALU: decodes alu_op/funct, registers result and flags; 1-cycle ops, optional WIDTH+1-cycle iterative MUL (ALU_EXEC_MUL_EN).
// Result holds in DONE until out_ready; no new request is accepted until the cycle after that handshake.
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LSL, OP_LSR, OP_NOT,
`ifdef ALU_EXEC_MUL_EN
      OP_MUL,
`endif
      OP_ILL
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef ALU_EXEC_MUL_EN
      S_BUSY = 2'd2,
`endif
      S_DONE = 2'd1
   } state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_err;

   op_t              w_op;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_lt;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;

   always_comb begin
      w_op = OP_ILL;
      case (alu_op)
         3'b000: begin
            case (funct)
               6'd0:    w_op = OP_ADD;
               6'd1:    w_op = OP_SUB;
               6'd2:    w_op = OP_AND;
               6'd3:    w_op = OP_OR;
               6'd4:    w_op = OP_SLT;
               6'd5:    w_op = OP_LSL;
               6'd6:    w_op = OP_LSR;
               6'd7:    w_op = OP_NOT;
`ifdef ALU_EXEC_MUL_EN
               6'd8:    w_op = OP_MUL;
`endif
               default: w_op = OP_ILL;
            endcase
         end
         3'b001:  w_op = OP_SUB;
         3'b010:  w_op = OP_SLT;
         3'b011:  w_op = OP_ADD;
         default: w_op = OP_ILL;
      endcase
   end

   assign w_sum  = a + b;
   assign w_diff = a - b;
   assign w_lt   = $signed(a) < $signed(b);

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_res = w_sum;
            w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_diff;
            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
         OP_LSL:  w_res = a << b[SHW-1:0];
         OP_LSR:  w_res = a >> b[SHW-1:0];
         OP_NOT:  w_res = ~a;
         default: w_res = '0;
      endcase
   end

`ifdef ALU_EXEC_MUL_EN
   localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_acc;
   logic [SHW:0]     r_cnt;
   logic [WIDTH-1:0] w_acc_nxt;

   assign w_acc_nxt = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
                  if (w_op == OP_MUL) begin
                     r_a_sh  <= a;
                     r_b_sh  <= b;
                     r_acc   <= '0;
                     r_cnt   <= CNT_INIT;
                     r_state <= S_BUSY;
                  end else
`endif
                  begin
                     r_result    <= w_res;
                     r_zero      <= (w_res == '0);
                     r_ovf       <= w_ovf;
                     r_err       <= (w_op == OP_ILL);
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
`ifdef ALU_EXEC_MUL_EN
            // Final iteration writes the accumulator's next value straight to the result.
            S_BUSY: begin
               if (r_cnt == (SHW+1)'(1)) begin
                  r_result    <= w_acc_nxt;
                  r_zero      <= (w_acc_nxt == '0);
                  r_ovf       <= 1'b0;
                  r_err       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_acc  <= w_acc_nxt;
                  r_a_sh <= r_a_sh << 1;
                  r_b_sh <= r_b_sh >> 1;
                  r_cnt  <= r_cnt - 1'b1;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign ovf       = r_ovf;
   assign err       = r_err;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised, handshaked successor to the combinational alu_control + ALU pair.
- Accepts alu_op/funct plus two operands and decodes them internally into an ALU operation.
- Executes the operation and returns a registered result with zero/overflow/error flags.
- Adds an iterative shift-add multiply as a multi-cycle operation; this is why the block needs a small FSM and valid/ready handshakes.
- Sits between the decode stage and writeback in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from b.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- alu_op  input  3  main-control ALU op class.
- funct  input  6  R-type function field.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt or immediate).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- ovf  output  1  signed overflow (ADD/SUB only).
- err  output  1  illegal op decoded.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=0 during reset, then 1; out_valid=0, result=0, zero=0, ovf=0, err=0; multiply accumulator and counter cleared. Reset mid-multiply aborts the operation; no result is produced.
- Decode (on acceptance):
  - alu_op 000 uses funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LSL, 6 LSR, 7 NOT, 8 MUL (only with macro).
  - alu_op 001 → SUB; 010 → SLT; 011 → ADD; funct ignored.
  - Illegal: alu_op 100–111, or alu_op 000 with an unlisted funct.
- Arithmetic:
  - ADD/SUB: modulo 2^WIDTH. ovf set when operand signs match (ADD) or differ (SUB) and the result sign differs from a.
  - SLT: signed compare; result = {WIDTH-1 zeros, a<b}.
  - LSL/LSR: logical shift of a by b[SHW-1:0].
  - NOT: ~a; b ignored.
  - MUL: low WIDTH bits of unsigned a*b; ovf=0.
  - zero always reflects the registered result.
  - Illegal op: result=0, zero=1, ovf=0, err=1.
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - Once out_valid rises, result and flags stay stable until out_valid && out_ready; out_valid then falls.
- FSM:
  - IDLE: in_ready=1. On accept of a single-cycle or illegal op, register result/flags and go to DONE. On accept of MUL, latch a, b, clear accumulator, set counter=WIDTH, go to BUSY.
  - BUSY: in_ready=0. Each cycle: if b_sh[0], acc += a_sh; then a_sh <<= 1, b_sh >>= 1, counter--. When counter reaches 1 (final iteration), write result and go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE.
  - No input bypass: a new request is accepted no earlier than the cycle after the handshake completes.
- Latency, acceptance edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Throughput: at most one operation every 2 cycles.
- out_ready asserted while not DONE: ignored.
- in_valid while in_ready=0: ignored, not queued.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- Defined: funct 8 with alu_op 000 runs the iterative MUL through the BUSY state as specified above.
- Undefined: BUSY state and multiply datapath are not built; funct 8 is illegal (result=0, zero=1, err=1, 1-cycle latency).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → out_valid=0, result=0, err=0; in_ready=1 on the first cycle after release.
- Decode sweep (WIDTH=32), each followed by an immediate out_ready:
  - alu_op=000, funct 0..7, a=0x0000000C, b=0x00000003 → ADD 0xF, SUB 0x9, AND 0x0, OR 0xF, SLT 0x0, LSL 0x60, LSR 0x1, NOT 0xFFFFFFF3. Each result appears 1 cycle after accept.
  - alu_op=001/010/011 with funct=7 → SUB/SLT/ADD results as above.
- Flags:
  - ADD a=0x7FFFFFFF, b=1 → result 0x80000000, ovf=1.
  - SUB a=5, b=5 → result 0, zero=1, ovf=0.
  - SLT a=0xFFFFFFFF, b=1 → result 1.
  - alu_op=101 → err=1, result=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result stable, in_ready=0, in_valid pulses ignored. Raise out_ready → out_valid falls the next cycle, then in_ready=1.
- MUL (macro on), a=0x00001234, b=0x00000056:
  - Result 0x00061D78 exactly 33 cycles after accept.
  - a=0xFFFFFFFF, b=2 → 0xFFFFFFFE.
  - Assert rst_n=0 at BUSY cycle 10 → no out_valid; IDLE after release.
- Macro off: funct=8 → err=1, result=0, zero=1, latency 1 cycle.
